config_chain_loader: RTL
========================

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the downstream chain (1..65535).
REQ-002 SHALL have parameter DATA_W, default 8: width of one incoming configuration word.
REQ-003 SHALL have port prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a chain load.
REQ-006 SHALL have port in_data  input  DATA_W  configuration word, MSB shifted first.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port ccff_head  output  1  serial bit into the head of the configuration chain.
REQ-010 SHALL have port ccff_en  output  1  shift enable for the chain; the chain captures ccff_head on each prog_clk edge where ccff_en=1.
REQ-011 SHALL have port done  output  1  high while exactly CHAIN_LEN bits have been shifted since the last start.

Function
REQ-012 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE: in_ready=0, ccff_en=0; start=1 -> LOAD and bit counter cleared to 0.
REQ-014 LOAD: in_ready=1; word accepted when in_valid&in_ready; next state SHIFT with the word in the shift register; otherwise remain in LOAD.
REQ-015 SHIFT: ccff_en=1, ccff_head = shift-register MSB; each cycle shift left by one and increment the bit counter.
REQ-016 SHIFT exit: after DATA_W bits -> LOAD; when the bit counter reaches CHAIN_LEN -> DONE, taking priority over the word boundary.
REQ-017 Final partial word (CHAIN_LEN not a multiple of DATA_W): only the upper CHAIN_LEN mod DATA_W bits are shifted; the remaining low bits are discarded.
REQ-018 Throughput: one word per DATA_W+1 cycles; first ccff_en cycle is the cycle after acceptance.
REQ-019 DONE: done=1, in_ready=0, ccff_en=0; start=1 -> LOAD with counter cleared (done drops the same edge).
REQ-020 start SHALL be ignored in LOAD and SHIFT; in_valid SHALL be ignored when in_ready=0.
REQ-021 Bit counter width SHALL be clog2(CHAIN_LEN+1); it SHALL never exceed CHAIN_LEN.
REQ-022 ccff_head SHALL be 0 whenever ccff_en=0.
REQ-023 All outputs SHALL be driven directly from registers or the state decode, with no combinational path from in_valid/in_data to ccff_head.

Reset
REQ-024 pReset_n=0 SHALL asynchronously force state IDLE, counter 0, shift register 0, in_ready=0, ccff_en=0, ccff_head=0, done=0.
REQ-025 Reset mid-load SHALL abandon the load; the downstream chain contents are not cleared by this block, and a full reload after start is required.
REQ-026 Reset release SHALL take effect at the first prog_clk edge after pReset_n rises; start sampled on that edge is honoured.

Structure
REQ-027 The state encoding (2-bit IDLE=0, LOAD=1, SHIFT=2, DONE=3) SHALL live in the shared fabric package alongside the chain-length constants.
REQ-028 The block SHALL be one module with no sub-modules; the counter and shift register are inline.

Verification
REQ-029 CHAIN_LEN=16: start, words 0xA5 then 0x3C -> ccff_head over ccff_en cycles = 1010_0101_0011_1100; done=1 one cycle after the 16th shift.
REQ-030 CHAIN_LEN=12: words 0xA5, 0x3C -> 12 shifts 1010_0101_0011; low nibble of 0x3C never appears; DONE entered.
REQ-031 in_valid held low for 5 cycles in LOAD -> ccff_en stays 0, counter frozen; resumes correctly when in_valid rises.
REQ-032 start pulsed during SHIFT and in_valid pulsed during SHIFT -> no effect on the bit stream or the counter.
REQ-033 pReset_n asserted after 5 shifts -> all outputs 0 immediately (no clock edge); new start reloads from bit 0 and done is reached after CHAIN_LEN further shifts.
REQ-034 start in DONE -> done drops the next edge, in_ready=1; second full load reproduces the same bit stream.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// Shared fabric constants for configuration-chain programming: loader state
// encoding and default/maximum chain geometry.
package config_chain_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccl_state_e;

    localparam int CCL_CHAIN_LEN_DEF = 64;
    localparam int CCL_CHAIN_LEN_MAX = 65535;
    localparam int CCL_DATA_W_DEF    = 8;

endpackage

// File: rtl/config_chain_loader.sv
// Serialises DATA_W-bit configuration words MSB-first into a CHAIN_LEN-long
// flip-flop chain, one word per DATA_W+1 prog_clk cycles.
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = CCL_CHAIN_LEN_DEF,
    parameter int DATA_W    = CCL_DATA_W_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    output logic              done
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DATA_W);

    ccl_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                in_ready_q, ccff_en_q, ccff_head_q, done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    sr_d    = in_data;
                    wcnt_d  = '0;
                end
            end
            SHIFT: begin
                sr_d   = sr_q << 1;
                cnt_d  = cnt_q + 1'b1;
                wcnt_d = wcnt_q + 1'b1;
                // Chain end wins over the word boundary; a partial last word
                // simply never has its low bits shifted out.
                if (cnt_d == CNT_LAST) begin
                    state_d = DONE;
                end else if (wcnt_d == WCNT_LAST) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            sr_q        <= '0;
            in_ready_q  <= 1'b0;
            ccff_en_q   <= 1'b0;
            ccff_head_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            sr_q        <= sr_d;
            in_ready_q  <= (state_d == LOAD);
            ccff_en_q   <= (state_d == SHIFT);
            ccff_head_q <= (state_d == SHIFT) && sr_d[DATA_W-1];
            done_q      <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign ccff_en   = ccff_en_q;
    assign ccff_head = ccff_head_q;
    assign done      = done_q;

endmodule
